muldiv_seq: RTL and testbench

//  Multi-cycle unsigned MULTU/DIVU sequencer for the MIPS core; produces HI/LO.

---
 rtl/muldiv_seq.sv | 145 ++++++++++++++
 tb/tb_muldiv_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer producing HI/LO.
// Borrows the shared ALU for one add/sub step per clock, 32 steps per operation.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;     // multiplier X or quotient Q
  logic [WIDTH-1:0] m_q, m_d;     // multiplicand M or divisor D
  logic             op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] div_a;
  logic             carry;
  logic             div_ok;

  // The ALU has no carry-out, so the multiply carry is recovered from wrap-around;
  // acc[MSB] set means the true partial remainder exceeds 2^WIDTH, so it always fits.
  assign div_a  = {acc_q[WIDTH-2:0], x_q[WIDTH-1]};
  assign carry  = (alu_out < acc_q);
  assign div_ok = acc_q[WIDTH-1] | (div_a >= m_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    m_d     = m_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADD;

    case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d = ITER;
          op_d    = op;
          cnt_d   = '0;
          acc_d   = '0;
          if (op) begin
            x_d = rs_val;
            m_d = rt_val;
          end else begin
            x_d = rt_val;
            m_d = rs_val;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ITER: begin
        alu_b = m_q;
        if (op_q) begin
          alu_a  = div_a;
          alu_op = ALU_SUB;
          acc_d  = div_ok ? alu_out : div_a;
          x_d    = {x_q[WIDTH-2:0], div_ok};
        end else begin
          alu_a  = acc_q;
          alu_op = ALU_ADD;
          if (x_q[0]) begin
            acc_d = {carry, alu_out[WIDTH-1:1]};
            x_d   = {alu_out[0], x_q[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_q[WIDTH-1:1]};
            x_d   = {acc_q[0], x_q[WIDTH-1:1]};
          end
        end
        cnt_d = cnt_q + CW'(1);

        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          hi_d    = acc_d;
          lo_d    = x_d;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      m_q     <= '0;
      op_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      m_q     <= m_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ITER);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural shared ALU and hand-computed results.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        abort;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_out;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .abort   (abort),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Shared ALU stand-in: same-cycle combinational add/sub
  assign alu_out = (alu_op == 3'd3) ? (alu_a - alu_b) : (alu_a + alu_b);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation from the current cycle (cycle 0) and returns in its DONE cycle
  task automatic run_op(input string tag, input logic op_i, input logic [31:0] a,
                        input logic [31:0] b, input bit hold,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    int busy_n;
    int bad_op;
    lat    = 0;
    busy_n = 0;
    bad_op = 0;
    start  = 1'b1;
    op     = op_i;
    rs_val = a;
    rt_val = b;
    tick();
    lat = 1;
    if (!hold) start = 1'b0;
    while (!done && lat < 100) begin
      if (busy) begin
        busy_n++;
        if (alu_op !== (op_i ? 3'd3 : 3'd2)) bad_op++;
      end
      if (hold && busy_n == 32) start = 1'b0;
      tick();
      lat++;
    end
    check($sformatf("%s_latency", tag), lat, 33);
    check($sformatf("%s_busy_cycles", tag), busy_n, 32);
    check($sformatf("%s_alu_op", tag), bad_op, 0);
    check($sformatf("%s_hi", tag), hi, exp_hi);
    check($sformatf("%s_lo", tag), lo, exp_lo);
  endtask

  initial begin
    int done_seen;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 1'b0;
    rs_val  = '0;
    rt_val  = '0;
    abort   = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_alu_op", alu_op, 3'd2);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);

    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    check("mul_max_done_alu_a", alu_a, 0);
    tick();
    check("mul_max_back_idle", busy | done, 0);

    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
    tick();

    run_op("div_by_0", 1'b1, 32'h0000_1234, 32'd0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
    tick();

    // abort blocks a same-cycle start in IDLE
    start  = 1'b1;
    abort  = 1'b1;
    op     = 1'b0;
    rs_val = 32'd3;
    rt_val = 32'd5;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_blocks_start", busy, 0);

    // MULTU 3x5 aborted in cycle 10
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_after", busy, 0);
    check("abort_done_after", done, 0);
    check("abort_hi_kept", hi, 32'h0000_1234);
    check("abort_lo_kept", lo, 32'hFFFF_FFFF);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);
    run_op("mul_3x5", 1'b0, 32'd3, 32'd5, 1'b0, 32'd0, 32'd15);
    tick();

    // Carry path, then back-to-back DIVU issued in the DONE cycle
    run_op("mul_carry", 1'b0, 32'h8000_0000, 32'd2, 1'b0, 32'd1, 32'd0);
    run_op("div_b2b", 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF);
    tick();

    // start held through busy must not restart the operation
    run_op("div_hold", 1'b1, 32'd1000, 32'd33, 1'b1, 32'd10, 32'd30);
    tick();
    check("div_hold_idle", busy | done, 0);

    // Reset in cycle 15 of a DIVU
    start  = 1'b1;
    op     = 1'b1;
    rs_val = 32'd100;
    rt_val = 32'd7;
    tick();
    repeat (14) tick();
    check("rst_mid_busy_before", busy, 1);
    reset_n = 1'b0;
    start   = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
